mono_data_tx: RTL and testbench



---
 rtl/mono_data_pkg.sv | 37 +++
 rtl/mono_data_tx_if.sv | 27 ++
 rtl/mono_tx_fifo.sv | 52 +++++
 rtl/mono_data_tx.sv | 162 ++++++++++++++++
 tb/tb_mono_data_tx.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mono_data_pkg.sv
// Shared types and constants for the MONOPIX serial hit transmitter.
// The hit word is {COL, ROW, LE, TE}, 27 bits, shifted MSB first.
package mono_data_pkg;

    localparam int HIT_W   = 27;
    localparam int COL_W   = 6;
    localparam int ROW_W   = 9;
    localparam int TS_W    = 6;

    // Field offsets inside the serial word (LSB positions).
    localparam int TE_LSB  = 0;
    localparam int LE_LSB  = TE_LSB + TS_W;
    localparam int ROW_LSB = LE_LSB + TS_W;
    localparam int COL_LSB = ROW_LSB + ROW_W;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_FROZEN = 2'd1,
        TX_SHIFT  = 2'd2,
        TX_DRAIN  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [TS_W-1:0]  le;
        logic [TS_W-1:0]  te;
    } hit_t;

    // Snapshot counter width: log2(depth)+1, never narrower than 5 bits.
    function automatic int snap_w(input int depth);
        int w;
        w = $clog2(depth) + 1;
        return (w < 5) ? 5 : w;
    endfunction

endpackage

// File: rtl/mono_data_tx_if.sv
// Hit input and FREEZE/READ/TOKEN/DATA link of the MONOPIX transmitter.
// slave = transmitter side, master = hit source / receiver side.
interface mono_data_tx_if;
    import mono_data_pkg::*;

    logic             HIT_VALID;
    logic             HIT_READY;
    logic [HIT_W-1:0] HIT_DATA;
    logic             FREEZE;
    logic             READ;
    logic             TOKEN;
    logic             DATA;
    logic             BUSY;
    logic             PROTO_ERR;
    logic [7:0]       LOST_CNT;

    modport slave (
        input  HIT_VALID, HIT_DATA, FREEZE, READ,
        output HIT_READY, TOKEN, DATA, BUSY, PROTO_ERR, LOST_CNT
    );

    modport master (
        output HIT_VALID, HIT_DATA, FREEZE, READ,
        input  HIT_READY, TOKEN, DATA, BUSY, PROTO_ERR, LOST_CNT
    );

endinterface

// File: rtl/mono_tx_fifo.sv
// Synchronous hit buffer, DEPTH x HIT_W, with occupancy count.
// Head word is presented combinationally; push into a full buffer is ignored.
module mono_tx_fifo
    import mono_data_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   CLK40,
    input  logic                   nRST,
    input  logic                   i_push,
    input  hit_t                   i_data,
    input  logic                   i_pop,
    output hit_t                   o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    hit_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLK40) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); push+pop keeps count.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/mono_data_tx.sv
// MONOPIX serial hit transmitter: buffers hits, snapshots the buffer on the
// FREEZE rising edge, and shifts one word per READ out on DATA, MSB first.
// Optional feature macro MONO_DATA_TX_DROP_EN: never backpressure, drop hits
// into a full buffer and count them in LOST_CNT (saturating at 255).
module mono_data_tx
    import mono_data_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic           CLK40,
    input  logic           nRST,
    mono_data_tx_if.slave  bus
);
    localparam int CW = snap_w(DEPTH);
    localparam int FW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE   = TX_IDLE;
    localparam logic [1:0] S_FROZEN = TX_FROZEN;
    localparam logic [1:0] S_SHIFT  = TX_SHIFT;
    localparam logic [1:0] S_DRAIN  = TX_DRAIN;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_snap;
    logic [4:0]       r_bitcnt;
    logic [HIT_W-1:0] r_shreg;
    logic             r_busy;
    logic             r_token;
    logic             r_perr;
    logic             r_freeze_d;
    logic             r_live;
    logic             w_rise;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [FW-1:0]    w_count;
    hit_t             w_head;

    assign w_rise = bus.FREEZE && !r_freeze_d;
    // The pop happens one cycle after the READ is accepted (first SHIFT cycle).
    assign w_pop  = (r_state == S_SHIFT) && (r_bitcnt == '0) && !w_empty;

    mono_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK40   (CLK40),
        .nRST    (nRST),
        .i_push  (w_push),
        .i_data  (bus.HIT_DATA),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // HIT_READY stays low while in reset, then follows the buffer policy.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) r_live <= 1'b0;
        else       r_live <= 1'b1;
    end

`ifdef MONO_DATA_TX_DROP_EN
    logic [7:0] r_lost;

    assign w_ready = r_live;
    assign w_push  = bus.HIT_VALID && r_live && !w_full;

    // Count hits offered into a full buffer, saturating.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST)
            r_lost <= '0;
        else if (bus.HIT_VALID && r_live && w_full && (r_lost != 8'hFF))
            r_lost <= r_lost + 8'd1;
    end

    assign bus.LOST_CNT = r_lost;
`else
    assign w_ready      = r_live && !w_full;
    assign w_push       = bus.HIT_VALID && w_ready;
    assign bus.LOST_CNT = '0;
`endif

    // Link FSM: snapshot on FREEZE rise, accept READs, sequence 27-bit words.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            r_bitcnt   <= '0;
            r_perr     <= 1'b0;
            r_freeze_d <= 1'b0;
        end else begin
            r_freeze_d <= bus.FREEZE;
            case (r_state)
                S_IDLE: begin
                    // READ outside a freeze (including one coincident with the
                    // FREEZE edge) is a protocol error; the edge still wins.
                    if (bus.READ) r_perr <= 1'b1;
                    if (w_rise) begin
                        r_state <= S_FROZEN;
                        r_snap  <= CW'(w_count);
                    end
                end
                S_FROZEN: begin
                    if (bus.READ) begin
                        if (r_snap != '0) begin
                            r_snap   <= r_snap - CW'(1);
                            r_bitcnt <= '0;
                            r_state  <= S_SHIFT;
                        end else begin
                            r_perr <= 1'b1;
                        end
                    end else if (!bus.FREEZE) begin
                        r_state <= S_IDLE;
                        r_snap  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bus.READ) r_perr <= 1'b1;
                    r_bitcnt <= r_bitcnt + 5'd1;
                    // Leave one edge early so the next READ can land on the
                    // edge that retires the last bit.
                    if (r_bitcnt == 5'(HIT_W - 1)) begin
                        if (bus.FREEZE) begin
                            r_state <= S_FROZEN;
                        end else begin
                            r_state <= S_IDLE;
                            r_snap  <= '0;
                        end
                    end
                end
                S_DRAIN: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shift register: load on pop, otherwise shift left with zero fill so
    // DATA returns to 0 once the last bit has been sent.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            r_shreg <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (r_state == S_SHIFT);
            if (w_pop) r_shreg <= w_head;
            else       r_shreg <= {r_shreg[HIT_W-2:0], 1'b0};
        end
    end

    // TOKEN is registered one cycle behind the snapshot counter.
    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) r_token <= 1'b0;
        else       r_token <= ((r_state == S_FROZEN) || (r_state == S_SHIFT)) && (r_snap != '0);
    end

    assign bus.HIT_READY = w_ready;
    assign bus.TOKEN     = r_token;
    assign bus.DATA      = r_shreg[HIT_W-1];
    assign bus.BUSY      = r_busy;
    assign bus.PROTO_ERR = r_perr;

endmodule

// File: tb/tb_mono_data_tx.sv
// Self-checking bench for mono_data_tx: table-driven link sequences, hand
// written corner cases, and randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mono_data_tx;
    import mono_data_pkg::*;

    localparam int DEPTH = 16;
`ifdef MONO_DATA_TX_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    localparam int OP_PUSH  = 0;
    localparam int OP_FRZ   = 1;
    localparam int OP_READ  = 2;
    localparam int OP_UNFRZ = 3;

    typedef struct {
        int          op;
        logic [26:0] arg;   // hit word for PUSH, idle gap for READ
        logic        tok;   // TOKEN expected after the op
        logic [26:0] word;  // word expected on DATA for READ
    } vec_t;

    logic CLK40 = 1'b0;
    logic nRST  = 1'b1;
    mono_data_tx_if bus();

    mono_data_tx #(.DEPTH(DEPTH)) dut (
        .CLK40 (CLK40),
        .nRST  (nRST),
        .bus   (bus)
    );

    always #12.5 CLK40 = ~CLK40;

    int          n_chk = 0;
    int          n_err = 0;
    logic [26:0] mq[$];       // words the buffer should hold, head first
    int          m_snap = 0;  // snapshot words still to be read
    int          m_lost = 0;
    logic [26:0] last_word;
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    task automatic model_push(input logic [26:0] h, input bit acc);
        if (acc) mq.push_back(h);
        else if (DROP && m_lost < 255) m_lost++;
    endtask

    task automatic push(input logic [26:0] h);
        bit acc;
        acc = (mq.size() < DEPTH);
        chk("hit_ready", 32'(bus.HIT_READY), DROP ? 32'd1 : 32'(acc));
        bus.HIT_VALID = 1'b1;
        bus.HIT_DATA  = h;
        tick();
        bus.HIT_VALID = 1'b0;
        model_push(h, acc);
    endtask

    task automatic freeze_on();
        bus.FREEZE = 1'b1;
        tick();
        m_snap = mq.size();
        chk("token_pre", 32'(bus.TOKEN), 32'd0);
        tick();
        chk("token_rise", 32'(bus.TOKEN), 32'(m_snap != 0));
    endtask

    task automatic freeze_off();
        bus.FREEZE = 1'b0;
        tick();
        tick();
        m_snap = 0;
        chk("token_off", 32'(bus.TOKEN), 32'd0);
        chk("tail_busy", 32'(bus.BUSY), 32'd0);
        chk("tail_data", 32'(bus.DATA), 32'd0);
    endtask

    // One READ and the 27 bit times of its word. Optionally a stray READ at
    // bit time perr_at, FREEZE drop at drop_at, and a push on the pop edge.
    task automatic read_word(input int perr_at, input int drop_at,
                             input bit cpush, input logic [26:0] cval);
        logic [26:0] exp, w;
        int          nb;
        bit          acc;
        exp = mq.pop_front();
        m_snap--;
        // The head still occupies its slot on the edge where it is popped.
        acc = (mq.size() + 1 < DEPTH);
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        chk("busy_before", 32'(bus.BUSY), 32'd0);
        if (cpush) begin
            bus.HIT_VALID = 1'b1;
            bus.HIT_DATA  = cval;
        end
        w  = '0;
        nb = 0;
        for (int i = 1; i <= 27; i++) begin
            tick();
            if (i == 1) begin
                bus.HIT_VALID = 1'b0;
                if (cpush) model_push(cval, acc);
                chk("token_after_pop", 32'(bus.TOKEN), 32'(m_snap != 0));
            end
            w  = {w[25:0], bus.DATA};
            nb += int'(bus.BUSY);
            bus.READ = (i == perr_at);
            if (i == drop_at) bus.FREEZE = 1'b0;
        end
        last_word = w;
        chk("word", 32'(w), 32'(exp));
        chk("busy_len", 32'(nb), 32'd27);
    endtask

    task automatic do_reset();
        bus.FREEZE    = 1'b0;
        bus.READ      = 1'b0;
        bus.HIT_VALID = 1'b0;
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        tick();
        tick();
        mq.delete();
        m_snap = 0;
        m_lost = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int np, nrd, n;
        bus.HIT_VALID = 1'b0;
        bus.HIT_DATA  = '0;
        bus.FREEZE    = 1'b0;
        bus.READ      = 1'b0;

        // Reset values
        #2 nRST = 1'b0;
        #3;
        chk("rst_ready", 32'(bus.HIT_READY), 32'd0);
        chk("rst_token", 32'(bus.TOKEN), 32'd0);
        chk("rst_data",  32'(bus.DATA), 32'd0);
        chk("rst_busy",  32'(bus.BUSY), 32'd0);
        chk("rst_perr",  32'(bus.PROTO_ERR), 32'd0);
        chk("rst_lost",  32'(bus.LOST_CNT), 32'd0);
        tick();
        tick();
        nRST = 1'b1;
        tick();
        chk("rel_ready", 32'(bus.HIT_READY), 32'd1);

        // Basic readout (READs 30 cycles apart) and snapshot isolation
        tbl.push_back(vec_t'{OP_PUSH,  27'h0000001, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_PUSH,  27'h7FFFFFF, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_PUSH,  27'h5555555, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_FRZ,   27'h0,       1'b1, 27'h0});
        tbl.push_back(vec_t'{OP_READ,  27'd2,       1'b1, 27'h0000001});
        tbl.push_back(vec_t'{OP_READ,  27'd2,       1'b1, 27'h7FFFFFF});
        tbl.push_back(vec_t'{OP_READ,  27'd2,       1'b0, 27'h5555555});
        tbl.push_back(vec_t'{OP_UNFRZ, 27'h0,       1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_PUSH,  27'h0ABCDEF, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_PUSH,  27'h1234567, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_FRZ,   27'h0,       1'b1, 27'h0});
        tbl.push_back(vec_t'{OP_PUSH,  27'h7654321, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_PUSH,  27'h0FEDCBA, 1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_READ,  27'd0,       1'b1, 27'h0ABCDEF});
        tbl.push_back(vec_t'{OP_READ,  27'd0,       1'b0, 27'h1234567});
        tbl.push_back(vec_t'{OP_UNFRZ, 27'h0,       1'b0, 27'h0});
        tbl.push_back(vec_t'{OP_FRZ,   27'h0,       1'b1, 27'h0});
        tbl.push_back(vec_t'{OP_READ,  27'd0,       1'b1, 27'h7654321});
        tbl.push_back(vec_t'{OP_READ,  27'd0,       1'b0, 27'h0FEDCBA});
        tbl.push_back(vec_t'{OP_UNFRZ, 27'h0,       1'b0, 27'h0});

        foreach (tbl[k]) begin
            case (tbl[k].op)
                OP_PUSH: push(tbl[k].arg);
                OP_FRZ: begin
                    freeze_on();
                    chk("tbl_token", 32'(bus.TOKEN), 32'(tbl[k].tok));
                end
                OP_READ: begin
                    read_word(-1, -1, 1'b0, '0);
                    chk("tbl_word", 32'(last_word), 32'(tbl[k].word));
                    chk("tbl_token", 32'(bus.TOKEN), 32'(tbl[k].tok));
                    repeat (int'(tbl[k].arg)) tick();
                end
                default: freeze_off();
            endcase
        end

        // FREEZE dropped mid-word with one snapshot word left
        push(27'h13579BD);
        push(27'h2468ACE);
        freeze_on();
        read_word(-1, 12, 1'b0, '0);
        m_snap = 0;
        tick();
        chk("drop_token", 32'(bus.TOKEN), 32'd0);
        chk("drop_busy",  32'(bus.BUSY), 32'd0);
        freeze_on();
        read_word(-1, -1, 1'b0, '0);
        chk("drop_kept", 32'(last_word), 32'h2468ACE);
        freeze_off();

        // Randomized traffic with concurrent push/pop and back-to-back READs
        for (int r = 0; r < 12; r++) begin
            np = $urandom_range(0, 6);
            for (int j = 0; j < np; j++) push(27'($urandom));
            freeze_on();
            nrd = $urandom_range(0, m_snap);
            for (int j = 0; j < nrd; j++) begin
                read_word(-1, -1, 1'($urandom_range(0, 1)), 27'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            freeze_off();
            chk("rnd_lost", 32'(bus.LOST_CNT), 32'(m_lost));
        end
        chk("rnd_perr", 32'(bus.PROTO_ERR), 32'd0);

        // Fill to DEPTH, then overflow
        do_reset();
        for (int j = 0; j < DEPTH; j++) push(27'($urandom));
        chk("full_ready", 32'(bus.HIT_READY), DROP ? 32'd1 : 32'd0);
        for (int j = 0; j < 5; j++) push(27'($urandom));
        chk("lost5", 32'(bus.LOST_CNT), DROP ? 32'd5 : 32'd0);
        for (int j = 0; j < 300; j++) push(27'($urandom));
        chk("lost_sat", 32'(bus.LOST_CNT), DROP ? 32'd255 : 32'd0);
        freeze_on();
        n = m_snap;
        chk("full_snap", 32'(n), 32'(DEPTH));
        for (int j = 0; j < n; j++) read_word(-1, -1, 1'b0, '0);
        freeze_off();
        chk("full_perr", 32'(bus.PROTO_ERR), 32'd0);

        // Stray READ at bit time 10 of an active word
        push(27'h2AAAAAA);
        freeze_on();
        read_word(10, -1, 1'b0, '0);
        chk("perr_shift", 32'(bus.PROTO_ERR), 32'd1);
        freeze_off();

        // Asynchronous reset in the middle of a word
        push(27'h7FFFFFF);
        push(27'h0000003);
        freeze_on();
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        repeat (4) tick();
        chk("mid_busy",  32'(bus.BUSY), 32'd1);
        chk("mid_data",  32'(bus.DATA), 32'd1);
        chk("mid_token", 32'(bus.TOKEN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("arst_data",  32'(bus.DATA), 32'd0);
        chk("arst_token", 32'(bus.TOKEN), 32'd0);
        chk("arst_busy",  32'(bus.BUSY), 32'd0);
        chk("arst_ready", 32'(bus.HIT_READY), 32'd0);
        bus.FREEZE = 1'b0;
        mq.delete();
        m_snap = 0;
        m_lost = 0;
        #3 nRST = 1'b1;
        tick();
        chk("arst_perr",  32'(bus.PROTO_ERR), 32'd0);
        chk("arst_ready1", 32'(bus.HIT_READY), 32'd1);

        // Buffer is empty after reset; READ with TOKEN=0 is an error
        freeze_on();
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        tick();
        chk("perr_empty",  32'(bus.PROTO_ERR), 32'd1);
        chk("token_empty", 32'(bus.TOKEN), 32'd0);
        chk("busy_empty",  32'(bus.BUSY), 32'd0);
        freeze_off();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
